// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: buffers parallel words in a small FIFO and shifts each
// word out one bit per clock as a bit_out/bit_valid stream. pause freezes the
// shifter (no load, no shift) without losing bits.
module serial_bit_feeder #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       pause,
    output logic                       bit_out,
    output logic                       bit_valid,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        StIdle,
        StShift
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             pop;
    logic             last_bit;
    logic             cur_bit;

    // Handshake, pop decision and status flags
    always_comb begin
        s_ready    = (level != LW'(DEPTH));
        push       = s_valid && s_ready;
        last_bit   = (cnt == CW'(WIDTH - 1));
        // Pop either from idle, or on the final bit so the next word follows without a gap
        pop        = !pause && (level != '0) &&
                     ((state == StIdle) || ((state == StShift) && last_bit));
        head       = mem[rd_ptr];
        busy       = (state == StShift) || (level != '0);
        fifo_level = level;
        cur_bit    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        shreg_next = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    end

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Shifter FSM with registered serial outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            shreg     <= '0;
            cnt       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    bit_valid <= 1'b0;
                    if (pop) begin
                        shreg <= head;
                        cnt   <= '0;
                        state <= StShift;
                    end
                end
                StShift: begin
                    if (pause) begin
                        // bit_out keeps its last value while stalled
                        bit_valid <= 1'b0;
                    end else begin
                        bit_out   <= cur_bit;
                        bit_valid <= 1'b1;
                        if (last_bit) begin
                            if (pop) begin
                                shreg <= head;
                                cnt   <= '0;
                            end else begin
                                state <= StIdle;
                            end
                        end else begin
                            shreg <= shreg_next;
                            cnt   <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Testbench for serial_bit_feeder: directed scenarios plus randomized traffic,
// with a bit-queue reference model checking every emitted bit.
module tb_serial_bit_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       pause = 1'b0;
    logic       bit_out;
    logic       bit_valid;
    logic       busy;
    logic [2:0] fifo_level;

    // Second instance, LSB first
    logic [7:0] s_data1 = 8'h00;
    logic       s_valid1 = 1'b0;
    logic       s_ready1;
    logic       pause1 = 1'b0;
    logic       bit_out1;
    logic       bit_valid1;
    logic       busy1;
    logic [2:0] fifo_level1;

    int checks = 0;
    int errors = 0;

    bit exp_q[$];
    logic prev_pause = 1'b0;
    logic last_out = 1'b0;

    serial_bit_feeder #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .pause      (pause),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    serial_bit_feeder #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data1),
        .s_valid    (s_valid1),
        .s_ready    (s_ready1),
        .pause      (pause1),
        .bit_out    (bit_out1),
        .bit_valid  (bit_valid1),
        .busy       (busy1),
        .fifo_level (fifo_level1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) prev_pause <= pause;

    // Reference model: every accepted word appends its bits, MSB first, to a queue;
    // every valid bit seen must be the queue head. Inputs are stable at negedge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            last_out = 1'b0;
        end else begin
            if (prev_pause) begin
                check("pause_bv", {31'd0, bit_valid}, 32'd0);
                check("pause_hold", {31'd0, bit_out}, {31'd0, last_out});
            end
            if (bit_valid) begin
                if (exp_q.size() == 0) check("extra_bit", {31'd0, bit_valid}, 32'd0);
                else check("bit", {31'd0, bit_out}, {31'd0, exp_q.pop_front()});
            end
            if (s_valid && s_ready) begin
                for (int i = 7; i >= 0; i--) exp_q.push_back(s_data[i]);
            end
            last_out = bit_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until it is taken (bounded)
    task automatic push_word(input logic [7:0] w);
        logic rdy;
        bit   done;
        done    = 1'b0;
        s_data  = w;
        s_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            rdy = s_ready;
            step();
            if (rdy) done = 1'b1;
        end
        s_valid = 1'b0;
        if (!done) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 400 && !idle; i++) begin
            if (!busy && !bit_valid && exp_q.size() == 0) idle = 1'b1;
            else step();
        end
        check("drain_q", exp_q.size(), 32'd0);
        check("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] a5;
        int         run;
        int         cnt;
        bit         seen;
        logic       rdy;

        a5 = 8'hA5;
        // Reset state
        step();
        step();
        check("rst_bv", {31'd0, bit_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_bitout", {31'd0, bit_out}, 32'd0);
        rst = 1'b0;
        step();
        check("rst_ready", {31'd0, s_ready}, 32'd1);

        // Single word 0xA5: bits after edges N+2..N+9
        push_word(a5);
        check("a5_level", {29'd0, fifo_level}, 32'd1);
        step();
        check("a5_load_bv", {31'd0, bit_valid}, 32'd0);
        check("a5_load_level", {29'd0, fifo_level}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            check("a5_bv", {31'd0, bit_valid}, 32'd1);
            check("a5_bit", {31'd0, bit_out}, {31'd0, a5[7-k]});
        end
        step();
        check("a5_end_bv", {31'd0, bit_valid}, 32'd0);
        check("a5_end_busy", {31'd0, busy}, 32'd0);
        drain();

        // Back-to-back 0x12, 0x9B: 16 contiguous valid bits
        push_word(8'h12);
        push_word(8'h9B);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bit_valid) seen = 1'b1;
            else step();
        end
        check("bb_start", {31'd0, bit_valid}, 32'd1);
        run = 0;
        for (int i = 0; i < 40 && bit_valid; i++) begin
            run++;
            step();
        end
        check("bb_run", run, 32'd16);
        drain();

        // Pause held from reset: 4 accepted, 5th held until a load frees a slot
        pause = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) push_word(8'h30 + 8'(i));
        check("p_level4", {29'd0, fifo_level}, 32'd4);
        check("p_ready0", {31'd0, s_ready}, 32'd0);
        check("p_busy", {31'd0, busy}, 32'd1);
        s_data  = 8'hE7;
        s_valid = 1'b1;
        step();
        step();
        step();
        check("p_held_level", {29'd0, fifo_level}, 32'd4);
        check("p_held_bv", {31'd0, bit_valid}, 32'd0);
        pause = 1'b0;
        step();
        check("p_load_level", {29'd0, fifo_level}, 32'd3);
        check("p_load_ready", {31'd0, s_ready}, 32'd1);
        step();
        s_valid = 1'b0;
        check("p_5th_level", {29'd0, fifo_level}, 32'd4);
        drain();

        // 0x92 with pause pulsed for 3 cycles after the 3rd bit
        push_word(8'h92);
        for (int i = 0; i < 4; i++) step();
        check("pp_bit3_bv", {31'd0, bit_valid}, 32'd1);
        check("pp_bit3", {31'd0, bit_out}, 32'd0);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("pp_bv", {31'd0, bit_valid}, 32'd0);
            check("pp_hold", {31'd0, bit_out}, 32'd0);
        end
        pause = 1'b0;
        step();
        check("pp_resume_bv", {31'd0, bit_valid}, 32'd1);
        check("pp_resume_bit", {31'd0, bit_out}, 32'd1);
        drain();

        // Async reset mid-word of 0xFF with 2 words buffered
        push_word(8'hFF);
        push_word(8'h3C);
        push_word(8'hC3);
        check("r_level2", {29'd0, fifo_level}, 32'd2);
        step();
        step();
        step();
        check("r_bv_before", {31'd0, bit_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("r_bv", {31'd0, bit_valid}, 32'd0);
        check("r_level", {29'd0, fifo_level}, 32'd0);
        check("r_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bit_valid) cnt++;
        end
        check("r_no_bits", cnt, 32'd0);

        // LSB-first instance, word 0x01
        s_data1  = 8'h01;
        s_valid1 = 1'b1;
        step();
        s_valid1 = 1'b0;
        step();
        check("lsb_load_bv", {31'd0, bit_valid1}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            check("lsb_bv", {31'd0, bit_valid1}, 32'd1);
            check("lsb_bit", {31'd0, bit_out1}, (k == 0) ? 32'd1 : 32'd0);
        end
        step();
        check("lsb_end_bv", {31'd0, bit_valid1}, 32'd0);

        // Randomized traffic with random pause, checked by the bit queue
        for (int i = 0; i < 2000; i++) begin
            rdy = s_ready;
            step();
            if (s_valid && rdy) s_valid = 1'b0;
            if (!s_valid && $urandom_range(0, 9) < 3) begin
                s_valid = 1'b1;
                s_data  = 8'($urandom);
            end
            pause = ($urandom_range(0, 7) == 0);
        end
        // Let any presented word be taken before draining
        for (int i = 0; i < 100 && s_valid; i++) begin
            rdy = s_ready;
            pause = 1'b0;
            step();
            if (rdy) s_valid = 1'b0;
        end
        s_valid = 1'b0;
        pause   = 1'b0;
        drain();
        check("final_level", {29'd0, fifo_level}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Upstream feeder for the serial pattern-detector stage.
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out one bit per clock as a bit_out/bit_valid stream, which drives the detector's in/valid inputs directly.
- pause input lets the consumer side throttle the stream without losing bits.

Parameters:
- WIDTH, 8, bits per input word.
- DEPTH, 4, FIFO depth in words (power of 2, >=2).
- MSB_FIRST, 1, 1 = serialize MSB first; 0 = LSB first.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_data  input  WIDTH  parallel word to serialize.
- s_valid  input  1  s_data valid.
- s_ready  output  1  FIFO can accept a word this cycle.
- pause  input  1  stall: no load, no shift while high.
- bit_out  output  1  serial data bit; drives detector in.
- bit_valid  output  1  bit_out valid this cycle; drives detector valid.
- busy  output  1  FIFO non-empty or shifter active.
- fifo_level  output  $clog2(DEPTH+1)  words currently in FIFO (excludes the word in the shifter).

Behaviour:
- Reset (async, rst=1): FIFO pointers and level cleared; shifter state IDLE; bit counter cleared; bit_out=0, bit_valid=0, busy=0. s_ready=1 once rst deasserts.
- Reset mid-word: the partial word and all buffered words are discarded, with no further bit_valid.
- s_ready = (fifo_level != DEPTH). It is combinational from the level only, with no pop-bypass: when full, a same-cycle pop does not allow a push.
- Push occurs on a clock edge with s_valid && s_ready.
- s_valid while !s_ready: the word is not taken and the source must hold it. There is no overflow path.
- Shifter FSM has two states, IDLE and SHIFT.
- IDLE:
  - If fifo_level != 0 and !pause: pop the head word into the shift register, clear the bit counter, go to SHIFT.
  - bit_valid=0 in IDLE.
- SHIFT with !pause:
  - Register bit_out = current MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0) of the shift register, with bit_valid=1.
  - Shift by one and increment the counter.
- SHIFT on the edge that emits bit WIDTH-1:
  - If fifo_level != 0 and !pause: pop the next word in the same edge and stay in SHIFT, so the stream has no gap.
  - Otherwise return to IDLE.
- SHIFT with pause=1: bit_valid=0, bit_out holds its last value, shift register and counter frozen. Resumes with the next unsent bit.
- pause also blocks the IDLE→SHIFT load.
- Latency: word pushed at edge N into an empty FIFO with an idle shifter → loaded at edge N+1 → bits visible after edges N+2 .. N+1+WIDTH.
- Simultaneous push and pop (not full): fifo_level unchanged. Pointers wrap modulo DEPTH.
- busy = (state == SHIFT) || (fifo_level != 0).
- Throughput: one bit per clock; sustained when a word is pushed at least every WIDTH cycles.

Test Plan:
- Single word 0xA5, MSB_FIRST=1, pause=0, pushed at edge N → bit_valid high for exactly 8 cycles after edges N+2..N+9, bits 1,0,1,0,0,1,0,1; then bit_valid=0, busy=0.
- Back-to-back words 0x12, 0x9B pushed on consecutive edges → 16 contiguous bit_valid cycles: 00010010 10011011, with no gap between words.
- pause=1 held from reset, then 5 pushes attempted → 4 accepted, fifo_level=4, s_ready=0 with the 5th held. Release pause → shifter loads (level 3, s_ready=1), 5th word accepted; 40 bits emitted in push order.
- 0x92 streaming with pause pulsed for 3 cycles after the 3rd bit → bit_valid low for those 3 cycles, bit_out held at 0. Remaining bits continue 10010 without loss; the downstream detector asserts its match.
- rst asserted asynchronously mid-word of 0xFF (after 4 bits) with 2 words buffered → bit_valid=0, fifo_level=0, busy=0 immediately. After release, no further bits are emitted until a new push.
- MSB_FIRST=0, word 0x01 → first emitted bit 1, followed by seven 0s.
